// File: rtl/instr_fetch_decode_pkg.sv
// instr_fetch_decode_pkg: opcodes, IR field positions and fetch FSM encodings
package instr_fetch_decode_pkg;
  localparam int OPCODE_WIDTH = 4;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMPI = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ALU  = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_ALUI = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_BR   = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] OP_ST   = 4'h6;
  localparam int IR_OP_LO  = 12;
  localparam int IR_RD_LO  = 9;
  localparam int IR_RS1_LO = 6;
  localparam int IR_RS2_LO = 3;
  localparam int REG_W     = 3;
  localparam int IMM6_W    = 6;
  localparam int IMM12_W   = 12;
  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_REQ  = 2'd1;
  localparam logic [1:0] FS_WAIT = 2'd2;
  localparam logic [1:0] FS_DONE = 2'd3;
  function automatic logic is_defined(input logic [OPCODE_WIDTH-1:0] op);
    return op inside {OP_JMP, OP_JMPI, OP_ALU, OP_ALUI, OP_BR, OP_LD, OP_ST};
  endfunction
endpackage

// File: rtl/instr_fetch_decode_if.sv
// instr_fetch_decode_if: instruction memory read bus with req/ack handshake
interface instr_fetch_decode_if #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational split of the IR into opcode, registers and immediates
module instr_field_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0]      ir,
  output logic [OPCODE_WIDTH-1:0] codop,
  output logic [REG_W-1:0]        rd,
  output logic [REG_W-1:0]        rs1,
  output logic [REG_W-1:0]        rs2,
  output logic [INSTR_W-1:0]      imm6,
  output logic [INSTR_W-1:0]      imm12,
  output logic                    illegal
);
  assign codop   = ir[IR_OP_LO +: OPCODE_WIDTH];
  assign rd      = ir[IR_RD_LO +: REG_W];
  assign rs1     = ir[IR_RS1_LO +: REG_W];
  assign rs2     = ir[IR_RS2_LO +: REG_W];
  assign imm6    = {{(INSTR_W-IMM6_W){ir[IMM6_W-1]}}, ir[IMM6_W-1:0]};
  assign imm12   = {{(INSTR_W-IMM12_W){ir[IMM12_W-1]}}, ir[IMM12_W-1:0]};
  assign illegal = !is_defined(codop);
endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetches one instruction word per strobe into the IR and decodes it
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_start,
  input  logic [ADDR_W-1:0]       pc,
  instr_fetch_decode_if.master    bus,
  output logic                    busy,
  output logic                    ir_valid,
  output logic [OPCODE_WIDTH-1:0] codop,
  output logic [REG_W-1:0]        rd,
  output logic [REG_W-1:0]        rs1,
  output logic [REG_W-1:0]        rs2,
  output logic [INSTR_W-1:0]      imm6,
  output logic [INSTR_W-1:0]      imm12,
  output logic                    illegal,
  output logic                    fault
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  addr;
  logic               timed_out;
  assign timed_out    = cnt == CNT_W'(TIMEOUT - 1);
  assign bus.mem_req  = state == FS_REQ || state == FS_WAIT;
  assign bus.mem_addr = addr;
  assign busy         = bus.mem_req;
  assign ir_valid     = state == FS_DONE;
  // Fetch sequencing: an ack in WAIT beats a timeout on the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FS_IDLE;
      cnt   <= '0;
      ir    <= '0;
      addr  <= '0;
      fault <= 1'b0;
    end else begin
      case (state)
        FS_IDLE: if (fetch_start && !fault) begin
          addr  <= pc;
          state <= FS_REQ;
        end
        FS_REQ: begin
          cnt   <= '0;
          state <= FS_WAIT;
        end
        FS_WAIT: if (bus.mem_ack) begin
          ir    <= bus.mem_rdata;
          cnt   <= '0;
          state <= FS_DONE;
        end else if (timed_out) begin
          fault <= 1'b1;
          cnt   <= '0;
          state <= FS_IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= FS_IDLE;
      endcase
    end
  end
  instr_field_decode #(.INSTR_W(INSTR_W)) u_dec (
    .ir      (ir),
    .codop   (codop),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm6    (imm6),
    .imm12   (imm12),
    .illegal (illegal)
  );
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed fetches with a scoreboard checked on every ir_valid
module tb_instr_fetch_decode;
  localparam int TO = 8;
  logic        clk = 0;
  logic        reset = 1;
  logic        fetch_start = 0;
  logic [15:0] pc = 0;
  logic        busy, ir_valid, illegal, fault;
  logic [3:0]  codop;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] imm6, imm12;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    int          cyc;
    logic [3:0]  codop;
    logic [2:0]  rd, rs1, rs2;
    logic [15:0] imm6, imm12;
    logic        ill;
  } exp_t;
  exp_t sb[$];
  instr_fetch_decode_if #(.INSTR_W(16), .ADDR_W(16)) bus ();
  instr_fetch_decode #(.INSTR_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc(pc), .bus(bus),
    .busy(busy), .ir_valid(ir_valid), .codop(codop), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm6(imm6), .imm12(imm12), .illegal(illegal), .fault(fault)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (ir_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_ir_valid", 32'(ir_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("codop", 32'(codop), 32'(e.codop));
        chk("rd", 32'(rd), 32'(e.rd));
        chk("rs1", 32'(rs1), 32'(e.rs1));
        chk("rs2", 32'(rs2), 32'(e.rs2));
        chk("imm6", 32'(imm6), 32'(e.imm6));
        chk("imm12", 32'(imm12), 32'(e.imm12));
        chk("illegal", 32'(illegal), 32'(e.ill));
      end
    end
  end
  task automatic fetch(input logic [15:0] a, input logic [15:0] d, input int dly, input bit poke, input exp_t e);
    @(negedge clk);
    fetch_start = 1;
    pc = a;
    e.cyc = cyc + 3 + dly;
    sb.push_back(e);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      fetch_start = poke && i == 1;
      pc = ~a;
      chk("req_held", 32'(bus.mem_req), 1);
      chk("addr_stable", 32'(bus.mem_addr), 32'(a));
    end
    @(negedge clk);
    fetch_start = 0;
    bus.mem_ack = 1;
    bus.mem_rdata = d;
    chk("req_at_ack", 32'(bus.mem_req), 1);
    chk("addr_at_ack", 32'(bus.mem_addr), 32'(a));
    @(negedge clk);
    bus.mem_ack = 0;
    bus.mem_rdata = 16'hDEAD;
    fetch_start = poke;
    chk("req_low_in_done", 32'(bus.mem_req), 0);
    @(negedge clk);
    fetch_start = 0;
    chk("done_strobe_ignored", 32'(busy), 0);
    chk("fault_after_fetch", 32'(fault), 0);
  endtask
  initial begin
    bus.mem_ack = 0;
    bus.mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_fields", {codop, rd, rs1, rs2, 19'b0}, 0);
    chk("rst_imm", {imm6, imm12}, 0);
    chk("rst_illegal", 32'(illegal), 0);
    reset = 0;
    fetch(16'h0010, 16'h5A47, 0, 0, '{0, 4'h5, 3'd5, 3'd1, 3'd0, 16'h0007, 16'hFA47, 1'b0});
    fetch(16'h0200, 16'h3E2A, 5, 0, '{0, 4'h3, 3'd7, 3'd0, 3'd5, 16'hFFEA, 16'hFE2A, 1'b0});
    fetch(16'h0300, 16'h6123, TO - 1, 0, '{0, 4'h6, 3'd0, 3'd4, 3'd4, 16'hFFE3, 16'h0123, 1'b0});
    @(negedge clk);
    fetch_start = 1;
    pc = 16'h0500;
    @(negedge clk);
    fetch_start = 0;
    repeat (TO) @(negedge clk);
    chk("to_last_wait_req", 32'(bus.mem_req), 1);
    chk("to_no_early_fault", 32'(fault), 0);
    @(negedge clk);
    chk("to_fault_set", 32'(fault), 1);
    chk("to_req_dropped", 32'(bus.mem_req), 0);
    chk("to_busy_low", 32'(busy), 0);
    chk("to_ir_kept_op", 32'(codop), 'h6);
    chk("to_ir_kept_imm", 32'(imm6), 'hFFE3);
    fetch_start = 1;
    pc = 16'h0600;
    @(negedge clk);
    fetch_start = 0;
    chk("faulted_strobe_no_req", 32'(bus.mem_req), 0);
    chk("faulted_strobe_addr", 32'(bus.mem_addr), 'h0500);
    chk("fault_sticky", 32'(fault), 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("reset_clears_fault", 32'(fault), 0);
    chk("reset_clears_ir", 32'(codop), 0);
    fetch(16'h0040, 16'hF000, 2, 1, '{0, 4'hF, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1});
    chk("illegal_held", 32'(illegal), 1);
    @(negedge clk);
    fetch_start = 1;
    pc = 16'h0700;
    @(negedge clk);
    fetch_start = 0;
    @(negedge clk);
    chk("mid_wait_req", 32'(bus.mem_req), 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_rst_req", 32'(bus.mem_req), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ir", 32'(codop), 0);
    chk("mid_rst_illegal", 32'(illegal), 0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 0);
    bus.mem_ack = 1;
    bus.mem_rdata = 16'h2ABC;
    @(negedge clk);
    bus.mem_ack = 0;
    chk("late_ack_no_valid", 32'(ir_valid), 0);
    repeat (3) @(negedge clk);
    chk("late_ack_ir_unchanged", 32'(codop), 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
